mem_access_scheduler: RTL
=========================

// Module: mem_access_scheduler
// PURPOSE
//  Sequences the single-port data RAM shared by instruction fetch (IF) and the
//  memory_control stage (DM: LDR/STR/ADR). Arbitrates the two requesters, holds
//  the RAM command stable for a fixed RAM latency, and returns read data with a
//  one-cycle done pulse. Raises stall to the pipeline while a DM access is open.
// PARAMETERS
//  RAM_LATENCY  2  cycles ram_en/addr held before ram_rdata is valid (>=1)
//  MAX_STREAK   3  consecutive DM grants allowed while IF waits before IF wins
//  AW           32 address width
//  DW           32 data width
// PORTS
//  clk        in   1   system clock, rising edge
//  reset      in   1   asynchronous, active-high
//  if_req     in   1   fetch request, level, held until if_done
//  if_addr    in   AW  fetch address
//  if_done    out  1   one-cycle pulse: fetch complete, if_rdata valid
//  if_rdata   out  DW  fetched word, held until next fetch completes
//  dm_req     in   1   data request, level, held until dm_done
//  dm_rw      in   1   1=read (LDR/ADR), 0=write (STR)
//  dm_addr    in   AW  data address (SR1 / address bus)
//  dm_wdata   in   DW  store data (SR2)
//  dm_done    out  1   one-cycle pulse: data access complete
//  dm_rdata   out  DW  load result, updated only on read completion
//  ram_en     out  1   RAM command valid
//  ram_rw     out  1   1=read, 0=write
//  ram_addr   out  AW  RAM address
//  ram_wdata  out  DW  RAM write data
//  ram_rdata  in   DW  RAM read data, valid in last ACCESS cycle
//  stall      out  1   dm_req high or DM access in flight, and not dm_done
//  busy       out  1   FSM not IDLE
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, streak=0, latency counter=0, rdata regs=0.
//  FSM IDLE -> ACCESS -> RESP -> IDLE.
//  IDLE: no req -> stay. Any req -> grant; latch owner, addr, rw, wdata;
//   load cnt=RAM_LATENCY-1; go ACCESS next edge. IF requests are always reads.
//  Arbitration (IDLE, both req): DM wins unless streak==MAX_STREAK -> IF wins.
//   streak: +1 on DM grant while if_req=1 (saturates at MAX_STREAK);
//   cleared on IF grant; unchanged on DM grant with if_req=0.
//  ACCESS: ram_en=1, ram_rw/addr/wdata from latched values, stable every cycle;
//   cnt decrements; at cnt==0 capture ram_rdata (if read), go RESP.
//   ram_wdata=0 on reads.
//  RESP: ram_en=0; owner's done=1 for exactly this cycle; owner's rdata
//   register updated at the ACCESS->RESP edge so it is valid with done.
//   DM write: dm_rdata unchanged. -> IDLE. No grant is made in RESP.
//  Requester drops req on the edge after done; a req still high in IDLE is a
//   new access. Latency req->done = RAM_LATENCY+2 cycles from IDLE.
//  Req changes (addr/data) during ACCESS are ignored (latched at grant).
//  Req deasserted mid-access: access completes, done still pulses.
//  stall = (dm_req | owner==DM & busy) & ~dm_done; combinational.
//  Reset mid-access: asynchronous abort; ram_en drops immediately, no done
//   pulse, in-flight write may be partial (RAM responsibility).
// STRUCTURE
//  Package mem_sched_pkg: state enum {IDLE,ACCESS,RESP}; RW_READ=1'b1,
//   RW_WRITE=1'b0; owner enum {OWN_IF,OWN_DM}; opcodes OP_ADR=4'b1100,
//   OP_LDR=4'b1101, OP_STR=4'b1110 (decode to dm_rw upstream).
//  Sub-module mem_grant_arbiter: if_req, dm_req, grant_en -> owner + streak
//   counter; scheduler top holds FSM, latency counter, latches, rdata regs.
// TESTING
//  1 DM read alone, dm_addr=0x10, RAM word 0xDEADBEEF, LAT=2 -> ram_en high
//    2 cycles, dm_done at cycle 4, dm_rdata=0xDEADBEEF, stall low after done.
//  2 DM write addr=0x20 wdata=0x1234 -> ram_rw=0 for 2 cycles, dm_done,
//    dm_rdata unchanged; later read of 0x20 returns 0x1234.
//  3 IF+DM req same cycle -> DM granted first, IF granted next IDLE; if_done
//    exactly 4 cycles after dm_done.
//  4 if_req held, dm_req held for 5 accesses, MAX_STREAK=3 -> grants DM,DM,DM,
//    IF,DM...; streak clears on IF grant.
//  5 reset asserted mid-ACCESS -> ram_en/busy/stall 0 same cycle, no done
//    pulse; first access after reset behaves as scenario 1.
//  6 dm_addr changed during ACCESS -> ram_addr keeps granted value; LAT=1
//    config gives req->done of 3 cycles.

Source files
------------

// File: rtl/mem_access_scheduler_pkg.sv
// Shared types and constants for the data-RAM access scheduler.
//   state_e : scheduler FSM states
//   owner_e : which requester holds the current RAM access
//   RW_*    : RAM direction encoding
//   OP_*    : memory_control opcodes that map onto dm_rw upstream
package mem_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    typedef enum logic {
        OWN_IF,
        OWN_DM
    } owner_e;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    localparam logic [3:0] OP_ADR = 4'b1100;
    localparam logic [3:0] OP_LDR = 4'b1101;
    localparam logic [3:0] OP_STR = 4'b1110;

    // LDR and ADR read memory; STR writes it.
    function automatic logic op_to_rw(input logic [3:0] op);
        return (op == OP_STR) ? RW_WRITE : RW_READ;
    endfunction

endpackage

// File: rtl/mem_access_scheduler_if.sv
// Bundle of requester and RAM signals around the access scheduler.
//   master : scheduler side (takes requests and ram_rdata, drives done/rdata/RAM command)
//   slave  : requester + RAM side (the mirror image)
interface mem_access_scheduler_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_done;
    logic [DW-1:0] if_rdata;

    logic          dm_req;
    logic          dm_rw;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_done;
    logic [DW-1:0] dm_rdata;

    logic          ram_en;
    logic          ram_rw;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    logic          stall;
    logic          busy;

    modport master (
        input  if_req, if_addr, dm_req, dm_rw, dm_addr, dm_wdata, ram_rdata,
        output if_done, if_rdata, dm_done, dm_rdata,
        output ram_en, ram_rw, ram_addr, ram_wdata, stall, busy
    );

    modport slave (
        output if_req, if_addr, dm_req, dm_rw, dm_addr, dm_wdata, ram_rdata,
        input  if_done, if_rdata, dm_done, dm_rdata,
        input  ram_en, ram_rw, ram_addr, ram_wdata, stall, busy
    );

endinterface

// File: rtl/mem_grant_arbiter.sv
// Chooses IF or DM when the scheduler is ready to grant, and tracks how many
// DM grants in a row have been made while IF was waiting.
//   clk, reset  : clock, asynchronous active-high reset
//   if_req_i    : fetch request
//   dm_req_i    : data request
//   grant_en_i  : scheduler is taking a grant this cycle
//   grant_o     : some requester is asking
//   owner_o     : winner of arbitration this cycle
module mem_grant_arbiter
    import mem_sched_pkg::*;
#(
    parameter int unsigned MAX_STREAK = 3
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   if_req_i,
    input  logic   dm_req_i,
    input  logic   grant_en_i,
    output logic   grant_o,
    output owner_e owner_o
);

    localparam int unsigned SW = (MAX_STREAK < 1) ? 1 : $clog2(MAX_STREAK + 1);
    localparam logic [SW-1:0] StreakMax = SW'(MAX_STREAK);

    logic [SW-1:0] streak_q, streak_d;

    // DM has priority; a starved IF wins once DM has had MAX_STREAK turns.
    always_comb begin
        grant_o = if_req_i | dm_req_i;
        owner_o = OWN_DM;
        if (!dm_req_i) begin
            owner_o = OWN_IF;
        end else if (if_req_i && (streak_q == StreakMax)) begin
            owner_o = OWN_IF;
        end
    end

    always_comb begin
        streak_d = streak_q;
        if (grant_en_i && grant_o) begin
            if (owner_o == OWN_IF) begin
                streak_d = '0;
            end else if (if_req_i && (streak_q != StreakMax)) begin
                streak_d = streak_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/mem_access_scheduler.sv
// Sequences the single-port data RAM shared by instruction fetch (IF) and the
// memory_control stage (DM). A grant latches the command, which is held on the
// RAM for RAM_LATENCY cycles; the owner then sees a one-cycle done pulse with
// its read data already registered.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : requester handshakes, RAM command/data, stall and busy
module mem_access_scheduler
    import mem_sched_pkg::*;
#(
    parameter int unsigned RAM_LATENCY = 2,
    parameter int unsigned MAX_STREAK  = 3,
    parameter int unsigned AW          = 32,
    parameter int unsigned DW          = 32
) (
    input  logic clk,
    input  logic reset,
    mem_access_scheduler_if.master bus
);

    localparam int unsigned CW = (RAM_LATENCY > 1) ? $clog2(RAM_LATENCY) : 1;
    localparam logic [CW-1:0] CntLoad = CW'(RAM_LATENCY - 1);

    state_e        state_q, state_d;
    owner_e        owner_q, owner_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rw_q, rw_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          ram_en_q, ram_en_d;
    logic          if_done_q, if_done_d;
    logic          dm_done_q, dm_done_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] dm_rdata_q, dm_rdata_d;

    logic   grant_en;
    logic   arb_grant;
    owner_e arb_owner;

    assign grant_en = (state_q == IDLE);

    mem_grant_arbiter #(
        .MAX_STREAK (MAX_STREAK)
    ) u_arbiter (
        .clk        (clk),
        .reset      (reset),
        .if_req_i   (bus.if_req),
        .dm_req_i   (bus.dm_req),
        .grant_en_i (grant_en),
        .grant_o    (arb_grant),
        .owner_o    (arb_owner)
    );

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        rw_d       = rw_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        ram_en_d   = ram_en_q;
        if_done_d  = 1'b0;
        dm_done_d  = 1'b0;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;

        unique case (state_q)
            IDLE: begin
                if (arb_grant) begin
                    state_d  = ACCESS;
                    owner_d  = arb_owner;
                    cnt_d    = CntLoad;
                    ram_en_d = 1'b1;
                    if (arb_owner == OWN_IF) begin
                        rw_d    = RW_READ;
                        addr_d  = bus.if_addr;
                        wdata_d = '0;
                    end else begin
                        rw_d    = bus.dm_rw;
                        addr_d  = bus.dm_addr;
                        wdata_d = (bus.dm_rw == RW_READ) ? '0 : bus.dm_wdata;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d  = RESP;
                    ram_en_d = 1'b0;
                    // rdata is registered on this edge so it is valid with done.
                    if (owner_q == OWN_IF) begin
                        if_done_d  = 1'b1;
                        if_rdata_d = bus.ram_rdata;
                    end else begin
                        dm_done_d = 1'b1;
                        if (rw_q == RW_READ) begin
                            dm_rdata_d = bus.ram_rdata;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                // No grant here: a request still high is picked up in IDLE.
                state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                ram_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            owner_q    <= OWN_IF;
            cnt_q      <= '0;
            rw_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            ram_en_q   <= 1'b0;
            if_done_q  <= 1'b0;
            dm_done_q  <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            rw_q       <= rw_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            ram_en_q   <= ram_en_d;
            if_done_q  <= if_done_d;
            dm_done_q  <= dm_done_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    assign bus.ram_en    = ram_en_q;
    assign bus.ram_rw    = rw_q;
    assign bus.ram_addr  = addr_q;
    assign bus.ram_wdata = wdata_q;
    assign bus.if_done   = if_done_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_done   = dm_done_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.busy      = (state_q != IDLE);
    // Gated by reset so stall is released the moment an access is aborted.
    assign bus.stall     = ~reset & ~dm_done_q
                         & (bus.dm_req | ((owner_q == OWN_DM) & (state_q != IDLE)));

endmodule
